bht_predictor: RTL and testbench

Parametrised branch history table that replaces the single-counter branch predictor in the pipelined RISC-V core. It gives a combinational taken/not-taken prediction in ID from a table of saturating counters, indexed either bimodally or gshare-style. It is trained by resolved branches from EX. It also keeps update and mispredict statistics that the bench can print each cycle.

---
 rtl/bht_predictor.sv | 109 ++++++++++
 tb/tb_bht_predictor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - branch history table of saturating counters, bimodal or gshare indexed
//
// Purpose: combinational taken/not-taken prediction for the instruction in ID,
// trained by branches resolved in EX, with update/mispredict statistics.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             asynchronous active-high reset
//   lookup_pc_i       PC of the instruction in ID
//   predict_o         predicted direction (1 = taken)
//   predict_idx_o     table index used for the prediction, carried to EX
//   update_valid_i    a branch resolved this cycle
//   update_idx_i      index returned from EX
//   update_taken_i    actual outcome
//   update_pred_i     prediction originally made for the branch
//   ghr_o             global history register
//   num_update_o      count of accepted updates (wrapping)
//   num_mispredict_o  count of updates whose outcome differed from the prediction (wrapping)

module bht_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int INIT    = 1 << (CTR_W - 1),
    parameter int GSHARE  = 0,
    parameter int GHR_W   = 4,
    parameter int STAT_W  = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       lookup_pc_i,
    output logic              predict_o,
    output logic [IDX_W-1:0]  predict_idx_o,
    input  logic              update_valid_i,
    input  logic [IDX_W-1:0]  update_idx_i,
    input  logic              update_taken_i,
    input  logic              update_pred_i,
    output logic [GHR_W-1:0]  ghr_o,
    output logic [STAT_W-1:0] num_update_o,
    output logic [STAT_W-1:0] num_mispredict_o
);

    localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT);

    logic [CTR_W-1:0]  ctr [ENTRIES];
    logic [GHR_W-1:0]  ghr;
    logic [GHR_W-1:0]  ghr_next;
    logic [STAT_W-1:0] num_update;
    logic [STAT_W-1:0] num_mispredict;
    logic [IDX_W-1:0]  pc_idx;
    logic [IDX_W-1:0]  idx;
    logic [CTR_W-1:0]  upd_ctr;
    logic              unused_ghr_msb;
    logic              unused_pc;

    function automatic logic [CTR_W-1:0] sat_next(input logic [CTR_W-1:0] c, input logic taken);
        if (taken) begin
            return (&c) ? c : c + 1'b1;
        end else begin
            return (|c) ? c - 1'b1 : c;
        end
    endfunction

    // Word-aligned PC bits above the index and the byte offset do not select a counter.
    assign unused_pc = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

    // Shift the resolved outcome into the history; the oldest bit falls off the top.
    assign {unused_ghr_msb, ghr_next} = {ghr, update_taken_i};

    always_comb begin
        pc_idx = lookup_pc_i[IDX_W+1:2];
        if (GSHARE != 0) begin
            idx = pc_idx ^ IDX_W'(ghr);
        end else begin
            idx = pc_idx;
        end
        upd_ctr = sat_next(ctr[update_idx_i], update_taken_i);
        // Write-through: a lookup hitting the counter being trained sees the trained value.
        if (update_valid_i && (update_idx_i == idx)) begin
            predict_o = upd_ctr[CTR_W-1];
        end else begin
            predict_o = ctr[idx][CTR_W-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= INIT_CTR;
            end
            ghr            <= '0;
            num_update     <= '0;
            num_mispredict <= '0;
        end else if (update_valid_i) begin
            ctr[update_idx_i] <= upd_ctr;
            ghr               <= ghr_next;
            num_update        <= num_update + 1'b1;
            if (update_taken_i != update_pred_i) begin
                num_mispredict <= num_mispredict + 1'b1;
            end
        end
    end

    assign predict_idx_o    = idx;
    assign ghr_o            = ghr;
    assign num_update_o     = num_update;
    assign num_mispredict_o = num_mispredict;

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - directed scoreboard bench for bht_predictor

`timescale 1ns/1ps

module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [3:0]  upd_idx;
    logic        upd_taken;
    logic        upd_pred;

    logic        b_pred, g_pred, s_pred;
    logic [3:0]  b_idx, g_idx, s_idx;
    logic [3:0]  b_ghr, g_ghr, s_ghr;
    logic [15:0] b_nu, b_nm, g_nu, g_nm;
    logic [2:0]  s_nu, s_nm;

    bht_predictor dut_b (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
        .predict_o(b_pred), .predict_idx_o(b_idx),
        .update_valid_i(upd_valid), .update_idx_i(upd_idx),
        .update_taken_i(upd_taken), .update_pred_i(upd_pred),
        .ghr_o(b_ghr), .num_update_o(b_nu), .num_mispredict_o(b_nm)
    );

    bht_predictor #(.GSHARE(1), .GHR_W(4)) dut_g (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
        .predict_o(g_pred), .predict_idx_o(g_idx),
        .update_valid_i(upd_valid), .update_idx_i(upd_idx),
        .update_taken_i(upd_taken), .update_pred_i(upd_pred),
        .ghr_o(g_ghr), .num_update_o(g_nu), .num_mispredict_o(g_nm)
    );

    bht_predictor #(.STAT_W(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
        .predict_o(s_pred), .predict_idx_o(s_idx),
        .update_valid_i(upd_valid), .update_idx_i(upd_idx),
        .update_taken_i(upd_taken), .update_pred_i(upd_pred),
        .ghr_o(s_ghr), .num_update_o(s_nu), .num_mispredict_o(s_nm)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %0h with no expected value queued", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one update for exactly one rising edge, then go idle.
    task automatic train(input logic [3:0] i, input logic t, input logic p);
        cyc();
        upd_valid = 1'b1;
        upd_idx   = i;
        upd_taken = t;
        upd_pred  = p;
        cyc();
        upd_valid = 1'b0;
    endtask

    task automatic look_pred(input string tag, input logic [31:0] pc, input logic exp);
        lookup_pc = pc;
        push(tag, 32'(exp));
        #2;
        check(32'(b_pred));
    endtask

    initial begin
        rst       = 1'b1;
        lookup_pc = 32'h0;
        upd_valid = 1'b0;
        upd_idx   = 4'h0;
        upd_taken = 1'b0;
        upd_pred  = 1'b0;

        // Reset values are present before any clock edge.
        #2;
        push("rst_async_pred", 1);
        check(32'(b_pred));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        lookup_pc = 32'h0;
        push("rst_pred_pc00", 1);
        push("rst_idx_pc00", 0);
        #2;
        check(32'(b_pred));
        check(32'(b_idx));
        lookup_pc = 32'h10;
        push("rst_pred_pc10", 1);
        push("rst_idx_pc10", 4);
        #2;
        check(32'(b_pred));
        check(32'(b_idx));
        lookup_pc = 32'h3C;
        push("rst_pred_pc3c", 1);
        push("rst_idx_pc3c", 15);
        push("rst_ghr", 0);
        push("rst_num_update", 0);
        push("rst_num_mispredict", 0);
        #2;
        check(32'(b_pred));
        check(32'(b_idx));
        check(32'(b_ghr));
        check(32'(b_nu));
        check(32'(b_nm));

        // Decrement and aliasing at idx 4: 2 -> 1 -> 0 -> 0.
        train(4'd4, 1'b0, 1'b1);
        look_pred("dec1_pred", 32'h10, 1'b0);
        train(4'd4, 1'b0, 1'b1);
        look_pred("dec2_pred", 32'h10, 1'b0);
        train(4'd4, 1'b0, 1'b1);
        look_pred("dec3_pred", 32'h10, 1'b0);
        look_pred("alias_pc50_pred", 32'h50, 1'b0);
        look_pred("neighbour_pc14_pred", 32'h14, 1'b1);

        // Saturation going up: 0 -> 1 -> 2 -> 3 -> 3.
        train(4'd4, 1'b1, 1'b0);
        look_pred("inc1_pred", 32'h10, 1'b0);
        train(4'd4, 1'b1, 1'b0);
        look_pred("inc2_pred", 32'h10, 1'b1);
        train(4'd4, 1'b1, 1'b0);
        look_pred("inc3_pred", 32'h10, 1'b1);
        train(4'd4, 1'b1, 1'b0);
        look_pred("inc4_pred", 32'h10, 1'b1);
        // 3 -> 2: still taken only if the counter did not wrap.
        train(4'd4, 1'b0, 1'b1);
        look_pred("sat_then_dec_pred", 32'h10, 1'b1);

        // Bypass: 2 -> 1 seen in the same cycle as the update.
        cyc();
        upd_valid = 1'b1;
        upd_idx   = 4'd4;
        upd_taken = 1'b0;
        upd_pred  = 1'b1;
        lookup_pc = 32'h10;
        push("bypass_same_cycle_pred", 0);
        #3;
        check(32'(b_pred));
        cyc();
        upd_valid = 1'b0;
        look_pred("bypass_after_edge_pred", 32'h10, 1'b0);

        // Gshare history: T, T, N, T.
        cyc();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        train(4'd0, 1'b1, 1'b1);
        push("ghr_after_t", 4'b0001);
        #2;
        check(32'(g_ghr));
        train(4'd0, 1'b1, 1'b1);
        push("ghr_after_tt", 4'b0011);
        #2;
        check(32'(g_ghr));
        train(4'd0, 1'b0, 1'b1);
        push("ghr_after_ttn", 4'b0110);
        #2;
        check(32'(g_ghr));
        train(4'd0, 1'b1, 1'b1);
        lookup_pc = 32'h10;
        push("ghr_after_ttnt", 4'b1101);
        push("gshare_idx_pc10", 9);
        push("bimodal_idx_pc10", 4);
        push("bimodal_ghr_shifts", 4'b1101);
        #2;
        check(32'(g_ghr));
        check(32'(g_idx));
        check(32'(b_idx));
        check(32'(b_ghr));

        // Statistics: 5 updates, 2 mispredicts.
        cyc();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        train(4'd1, 1'b1, 1'b1);
        train(4'd1, 1'b0, 1'b1);
        train(4'd2, 1'b1, 1'b1);
        train(4'd2, 1'b1, 1'b0);
        train(4'd3, 1'b0, 1'b0);
        push("stat_num_update_5", 5);
        push("stat_num_mispredict_2", 2);
        #2;
        check(32'(b_nu));
        check(32'(b_nm));
        for (int k = 0; k < 4; k++) begin
            train(4'd5, 1'b1, 1'b1);
        end
        push("stat_num_update_9", 9);
        push("stat3_num_update_wrap", 1);
        push("stat3_num_mispredict", 2);
        #2;
        check(32'(b_nu));
        check(32'(s_nu));
        check(32'(s_nm));

        // Asynchronous reset mid-run.
        cyc();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        train(4'd4, 1'b0, 1'b1);
        train(4'd4, 1'b0, 1'b1);
        look_pred("pre_async_pred", 32'h10, 1'b0);
        #1;
        rst = 1'b1;
        push("async_rst_pred", 1);
        push("async_rst_num_update", 0);
        #1;
        check(32'(b_pred));
        check(32'(b_nu));
        // An update held across an edge while reset is asserted must not train.
        upd_valid = 1'b1;
        upd_idx   = 4'd4;
        upd_taken = 1'b0;
        upd_pred  = 1'b1;
        cyc();
        upd_valid = 1'b0;
        rst       = 1'b0;
        push("held_update_ignored_pred", 1);
        push("held_update_ignored_nu", 0);
        push("held_update_ignored_ghr", 0);
        #2;
        check(32'(b_pred));
        check(32'(b_nu));
        check(32'(b_ghr));
        // First edge after reset release trains normally: 2 -> 1.
        train(4'd4, 1'b0, 1'b1);
        lookup_pc = 32'h10;
        push("post_rst_update_pred", 0);
        push("post_rst_update_nu", 1);
        push("post_rst_update_nm", 1);
        #2;
        check(32'(b_pred));
        check(32'(b_nu));
        check(32'(b_nm));

        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d unchecked entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
